// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state codes and default timing for the buffer read path.
package fifo_reader_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3
  } state_t;
  localparam int HOLD_BASE_DEF = 4;
  localparam int TIMEOUT_DEF   = 8;
  localparam int CNT_W         = 16;
endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: read-side handshake between a buffer and its reader.
interface fifo_reader_if #(parameter int DATA_W = 16);
  logic              rd_en;
  logic              buffer_empty;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  modport master(output rd_en, input buffer_empty, data_valid, data_in);
  modport slave(input rd_en, output buffer_empty, data_valid, data_in);
endinterface

// File: rtl/fifo_reader_parity_calc.sv
// fifo_reader_parity_calc: even-parity bit as the XOR reduction of a word.
module fifo_reader_parity_calc #(parameter int DATA_W = 16) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);
  assign parity = ^data;
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: requests words from a buffer, captures them, then holds or drains.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int HOLD_BASE = HOLD_BASE_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              drain,
  input  logic [2:0]        prog,
  fifo_reader_if.master     buf_if,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity,
  output logic [7:0]        word_cnt,
  output logic              timeout_err,
  output logic              drain_done
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hold_q, hold_d, tmo_q, tmo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ov_q, ov_d, err_q, err_d, dd_q, dd_d, dd_seen_q, dd_seen_d;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    ov_d    = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if ((enable | drain) & ~buf_if.buffer_empty) state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT:
        if (buf_if.data_valid) begin
          data_d  = buf_if.data_in;
          ov_d    = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = drain ? S_IDLE : S_HOLD;
          hold_d  = CNT_W'(HOLD_BASE * (int'(prog) + 1) - 1);
        end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else tmo_d = tmo_q + CNT_W'(1);
      S_HOLD:
        if (drain || hold_q == '0) state_d = S_IDLE;
        else hold_d = hold_q - CNT_W'(1);
      default: state_d = S_IDLE;
    endcase
    // the seen flag keeps a long drain from pulsing drain_done more than once
    dd_d      = drain & (state_q == S_IDLE) & buf_if.buffer_empty & ~buf_if.data_valid & ~dd_seen_q;
    dd_seen_d = drain & (dd_seen_q | dd_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      tmo_q     <= '0;
      data_q    <= '0;
      ov_q      <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      dd_q      <= 1'b0;
      dd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      ov_q      <= ov_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      dd_q      <= dd_d;
      dd_seen_q <= dd_seen_d;
    end
  end
  fifo_reader_parity_calc #(.DATA_W(DATA_W)) u_parity (.data(data_q), .parity(parity));
  assign buf_if.rd_en = (state_q == S_REQ);
  assign data_out     = data_q;
  assign out_valid    = ov_q;
  assign word_cnt     = cnt_q;
  assign timeout_err  = err_q;
  assign drain_done   = dd_q;
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed checks of capture, hold, timeout, drain, wrap and async reset.
module tb_fifo_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        drain = 1'b0;
  logic [2:0]  prog = 3'd0;
  logic [15:0] data_out;
  logic        out_valid, parity, timeout_err, drain_done;
  logic [7:0]  word_cnt;
  int total = 0;
  int bad = 0;
  fifo_reader_if #(.DATA_W(16)) bif ();
  fifo_reader #(.DATA_W(16), .HOLD_BASE(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .drain(drain), .prog(prog), .buf_if(bif),
    .data_out(data_out), .out_valid(out_valid), .parity(parity), .word_cnt(word_cnt),
    .timeout_err(timeout_err), .drain_done(drain_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic run_drain(input int n, input logic [15:0] w0, output int nrd, output int ndd, output int badgap);
    int last;
    int k;
    bit pend;
    nrd = 0; ndd = 0; badgap = 0; last = -3; k = 0; pend = 0;
    drain = 1'b1;
    bif.buffer_empty = 1'b0;
    for (int t = 0; t < 3 * n + 8; t++) begin
      tick();
      bif.data_valid = 1'b0;
      if (pend) begin
        bif.data_valid = 1'b1;
        bif.data_in = w0 + 16'(k);
        k++;
        pend = 0;
      end
      if (bif.rd_en) begin
        if (nrd > 0 && t - last != 3) badgap++;
        last = t;
        nrd++;
        pend = 1;
        if (nrd == n) bif.buffer_empty = 1'b1;
      end
      if (drain_done) ndd++;
    end
    bif.data_valid = 1'b0;
  endtask
  initial begin
    int n, nrd, ndd, badgap;
    bif.buffer_empty = 1'b1;
    bif.data_valid = 1'b0;
    bif.data_in = '0;
    tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_flags", {bif.rd_en, out_valid, parity, timeout_err, drain_done}, 0);
    rst = 1'b0;
    tick();
    enable = 1'b1; bif.buffer_empty = 1'b0; prog = 3'd2;
    tick();
    chk("basic_rd_en", bif.rd_en, 1);
    bif.buffer_empty = 1'b1;
    bif.data_valid = 1'b1; bif.data_in = 16'h5555;
    tick();
    chk("rd_en_one_cycle", bif.rd_en, 0);
    chk("dv_in_req_ignored", word_cnt, 0);
    bif.data_in = 16'h00FF;
    tick();
    chk("basic_out_valid", out_valid, 1);
    chk("basic_data_out", data_out, 16'h00FF);
    chk("basic_parity", parity, 0);
    chk("basic_word_cnt", word_cnt, 1);
    bif.data_valid = 1'b0; bif.buffer_empty = 1'b0; prog = 3'd7;
    tick();
    chk("out_valid_pulse", out_valid, 0);
    n = 1;
    while (!bif.rd_en && n < 40) begin
      tick();
      n++;
    end
    chk("hold_cycles_to_rd_en", n, 13);
    bif.buffer_empty = 1'b1;
    tick();
    repeat (7) tick();
    chk("timeout_not_early", timeout_err, 0);
    tick();
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_word_cnt", word_cnt, 1);
    chk("timeout_data_out", data_out, 16'h00FF);
    bif.data_valid = 1'b1; bif.data_in = 16'h1234;
    tick();
    tick();
    chk("idle_dv_no_count", word_cnt, 1);
    chk("idle_dv_no_pulse", out_valid, 0);
    chk("idle_no_rd_en", bif.rd_en, 0);
    chk("timeout_sticky", timeout_err, 1);
    bif.data_valid = 1'b0;
    run_drain(3, 16'h1230, nrd, ndd, badgap);
    chk("drain_rd_count", nrd, 3);
    chk("drain_gap_bad", badgap, 0);
    chk("drain_done_count", ndd, 1);
    chk("drain_word_cnt", word_cnt, 4);
    chk("drain_data_out", data_out, 16'h1232);
    chk("drain_parity", parity, 1);
    drain = 1'b0;
    tick();
    drain = 1'b1;
    ndd = 0;
    repeat (4) begin
      tick();
      if (drain_done) ndd++;
    end
    chk("drain_done_rearm", ndd, 1);
    drain = 1'b0;
    tick();
    run_drain(252, 16'hFF06, nrd, ndd, badgap);
    chk("wrap_rd_count", nrd, 252);
    chk("wrap_word_cnt", word_cnt, 0);
    chk("wrap_data_out", data_out, 16'h0001);
    chk("wrap_parity", parity, 1);
    drain = 1'b0;
    enable = 1'b1; bif.buffer_empty = 1'b0; prog = 3'd7;
    tick();
    chk("inflight_rd_en", bif.rd_en, 1);
    enable = 1'b0; bif.buffer_empty = 1'b1;
    tick();
    bif.data_valid = 1'b1; bif.data_in = 16'h8001;
    tick();
    chk("inflight_capture", out_valid, 1);
    chk("inflight_data_out", data_out, 16'h8001);
    chk("inflight_word_cnt", word_cnt, 1);
    bif.data_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data_out", data_out, 0);
    chk("async_rst_word_cnt", word_cnt, 0);
    chk("async_rst_flags", {bif.rd_en, out_valid, parity, timeout_err, drain_done}, 0);
    #2 rst = 1'b0;
    bif.data_valid = 1'b1; bif.data_in = 16'hFFFF;
    tick();
    tick();
    chk("stale_dv_word_cnt", word_cnt, 0);
    chk("stale_dv_data_out", data_out, 0);
    chk("stale_dv_out_valid", out_valid, 0);
    bif.data_valid = 1'b0;
    enable = 1'b1; bif.buffer_empty = 1'b0;
    tick();
    chk("abort_rd_en", bif.rd_en, 1);
    tick();
    bif.data_valid = 1'b1; bif.data_in = 16'h0003;
    tick();
    chk("abort_capture", data_out, 16'h0003);
    bif.data_valid = 1'b0; drain = 1'b1;
    n = 0;
    while (!bif.rd_en && n < 40) begin
      tick();
      n++;
    end
    chk("drain_aborts_hold", n, 2);
    drain = 1'b0; enable = 1'b0; bif.buffer_empty = 1'b1;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_W, default 16: word width read from the buffer read side.
REQ-002 Parameter HOLD_BASE, default 4: hold-time unit, in clk cycles.
REQ-003 Parameter TIMEOUT, default 8: maximum clk cycles to wait for data_valid after a read request.
REQ-004 Ports (name, direction, width, meaning):
- clk  input  1  single clock; all logic rises on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  level; permits new reads.
- drain  input  1  level; empty the buffer without hold time.
- prog  input  3  hold multiplier select.
- buffer_empty  input  1  buffer read side empty.
- data_valid  input  1  data_in valid this cycle.
- data_in  input  DATA_W  word from the buffer.
- rd_en  output  1  one-cycle read request to the buffer.
- data_out  output  DATA_W  last captured word.
- out_valid  output  1  one-cycle pulse on capture.
- parity  output  1  XOR reduction of data_out (even-parity bit).
- word_cnt  output  8  captured-word count.
- timeout_err  output  1  sticky; set when a read timed out.
- drain_done  output  1  one-cycle pulse when a drain completes.

Function
REQ-005 States: S_IDLE, S_REQ, S_WAIT, S_HOLD.
REQ-006 S_IDLE -> S_REQ when (enable | drain) & ~buffer_empty; otherwise stay in S_IDLE.
REQ-007 S_REQ drives rd_en=1 for exactly one cycle, then moves to S_WAIT; rd_en=0 in every other state.
REQ-008 S_WAIT, data_valid=1: same edge latches data_out<=data_in, parity<=^data_in, pulses out_valid, and increments word_cnt.
REQ-009 word_cnt wraps 255->0.
REQ-010 S_WAIT, data_valid=1: go to S_HOLD if drain=0, else to S_IDLE.
REQ-011 S_WAIT, no data_valid for TIMEOUT cycles: set timeout_err and return to S_IDLE; data_out, parity and word_cnt stay unchanged.
REQ-012 Entry to S_HOLD samples prog; the hold lasts HOLD_BASE*(prog+1) cycles, and prog changes during the hold are ignored.
REQ-013 S_HOLD returns to S_IDLE when the hold count expires.
REQ-014 S_HOLD returns to S_IDLE immediately if drain rises during the hold.
REQ-015 enable falling during S_REQ or S_WAIT does not abort the read: the in-flight word is still captured.
REQ-016 data_valid outside S_WAIT is ignored: no capture, no count.
REQ-017 drain_done pulses one cycle when drain=1, state=S_IDLE, buffer_empty=1 and data_valid=0.
REQ-018 drain_done re-arms only after drain falls.
REQ-019 drain and enable both high: drain behaviour (no hold) takes priority.
REQ-020 Back-to-back reads in drain mode: minimum 3 cycles per word (S_IDLE, S_REQ, S_WAIT with immediate data_valid).

Reset
REQ-021 rst=1 forces, asynchronously: state=S_IDLE, rd_en=0, data_out=0, parity=0, out_valid=0, word_cnt=0, timeout_err=0, drain_done=0, hold and timeout counters=0.
REQ-022 Reset asserted mid-S_WAIT or mid-S_HOLD abandons the transaction; a data_valid arriving after reset releases is ignored per REQ-016.
REQ-023 timeout_err clears only on rst.

Structure
REQ-024 State encodings (3-bit localparams) and the default HOLD_BASE/TIMEOUT values live in the shared project package, so the buffer write side and the display path use identical codes.
REQ-025 Single module; a parity_calc sub-module (combinational XOR reduce, parameterised on DATA_W) is allowed and reusable by the top-level parity output.

Verification
REQ-026 Basic read: enable=1, buffer_empty=0, data_valid one cycle after rd_en with data_in=16'h00FF -> data_out=16'h00FF, parity=0, word_cnt=1, out_valid pulse.
REQ-027 Hold time: prog=3'd2, HOLD_BASE=4 -> exactly 12 cycles in S_HOLD before the next rd_en.
REQ-028 Timeout: rd_en issued, data_valid never asserted -> timeout_err=1 after 8 cycles, state=S_IDLE, word_cnt unchanged.
REQ-029 Drain: 3 words queued, drain=1 -> 3 rd_en pulses 3 cycles apart, then buffer_empty=1 -> single drain_done pulse.
REQ-030 Wrap: 256 captures -> word_cnt returns to 0; data_in=16'h0001 -> parity=1.
REQ-031 Async reset: rst pulsed mid-S_HOLD (not aligned to clk) -> all outputs 0 immediately; a stale data_valid right after release -> no capture.
